// File: rtl/axi_burst_gate.sv
// axi_burst_gate: producer-side AXI-Stream burst framer.
// Admits upstream beats in bursts of BURST_LEN, starts a burst only when the
// downstream FIFO's almost_full is low, tags the final beat with tlast, and
// drives m_axis_* from a 2-entry skid buffer (head entry).
//
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   s_axis_tvalid/tdata/tready      upstream stream (tready from registered state)
//   fifo_almost_full                downstream FIFO threshold flag
//   m_axis_tvalid/tdata/tlast/tready downstream stream
//   burst_cnt                       completed bursts (tlast transfers), wraps
//   pad_active                      high while zero pad beats are generated
//
// Optional feature macro: AXI_BURST_GATE_PAD_EN
//   Defined:   a burst stalled for PAD_TIMEOUT idle cycles with at least one
//              beat accepted is completed with zero-data beats (PAD state).
//   Undefined: no PAD state; a stalled burst waits indefinitely.
module axi_burst_gate #(
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_LEN   = 16,
  parameter int CNT_WIDTH   = 8,
  parameter int PAD_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  input  logic                  fifo_almost_full,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  burst_cnt,
  output logic                  pad_active
);

  if (BURST_LEN < 2 || BURST_LEN > (1 << CNT_WIDTH) || PAD_TIMEOUT < 1) begin : g_cfg_chk
    $error("axi_burst_gate: illegal BURST_LEN/CNT_WIDTH/PAD_TIMEOUT combination");
  end

  typedef enum logic [1:0] {IDLE, BURST, PAD} state_e;

  state_e                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] d0_q, d1_q;
  logic                  l0_q, l1_q;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  bcnt_q;

  logic                  rdy;
  logic                  acc, push, pop, last_beat;
  logic [DATA_WIDTH-1:0] push_data;

  assign acc       = s_axis_tvalid & rdy;
  assign pop       = (occ_q != 2'd0) & m_axis_tready;
  assign last_beat = (beat_q == CNT_WIDTH'(BURST_LEN - 1));

`ifdef AXI_BURST_GATE_PAD_EN
  localparam int IW = $clog2(PAD_TIMEOUT + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          pad_go, pad_push, pad_act;

  assign pad_push  = (state_q == PAD) && (occ_q != 2'd2);
  assign push      = acc | pad_push;
  assign push_data = pad_push ? '0 : s_axis_tdata;
  // Transition fires during the PAD_TIMEOUT-th consecutive idle cycle.
  assign pad_go    = (state_q == BURST) && !s_axis_tvalid && (beat_q != '0) &&
                     (idle_q >= IW'(PAD_TIMEOUT - 1));

  always_comb begin
    idle_d = '0;
    if (state_q == BURST && !s_axis_tvalid)
      idle_d = (idle_q == IW'(PAD_TIMEOUT)) ? idle_q : idle_q + IW'(1);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) idle_q <= '0;
    else          idle_q <= idle_d;

  assign pad_active = pad_act;
`else
  assign push       = acc;
  assign push_data  = s_axis_tdata;
  assign pad_active = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!fifo_almost_full) state_d = BURST;
      BURST: begin
        // almost_full only matters at a burst boundary
        if (acc && last_beat) state_d = fifo_almost_full ? IDLE : BURST;
`ifdef AXI_BURST_GATE_PAD_EN
        else if (pad_go)      state_d = PAD;
`endif
      end
`ifdef AXI_BURST_GATE_PAD_EN
      PAD:   if (pad_push && last_beat) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs (registered state only)
  always_comb begin
    rdy = 1'b0;
`ifdef AXI_BURST_GATE_PAD_EN
    pad_act = 1'b0;
`endif
    case (state_q)
      BURST: rdy = (occ_q != 2'd2);
`ifdef AXI_BURST_GATE_PAD_EN
      PAD:   pad_act = 1'b1;
`endif
      default: ;
    endcase
  end

  assign s_axis_tready = rdy;

  always_comb begin
    beat_d = beat_q;
    if (state_q == IDLE) beat_d = '0;
    else if (push)       beat_d = last_beat ? '0 : beat_q + CNT_WIDTH'(1);
  end

  assign occ_d = occ_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q  <= '0;
      d0_q   <= '0;
      d1_q   <= '0;
      l0_q   <= 1'b0;
      l1_q   <= 1'b0;
      beat_q <= '0;
      bcnt_q <= '0;
    end else begin
      occ_q  <= occ_d;
      beat_q <= beat_d;
      if (pop && l0_q) bcnt_q <= bcnt_q + CNT_WIDTH'(1);
      // push is never raised with occ=2; pop never with occ=0
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin d0_q <= push_data; l0_q <= last_beat; end
          else               begin d1_q <= push_data; l1_q <= last_beat; end
        end
        2'b01: begin d0_q <= d1_q; l0_q <= l1_q; end
        2'b11: begin
          if (occ_q == 2'd1) begin
            d0_q <= push_data; l0_q <= last_beat;
          end else begin
            d0_q <= d1_q;      l0_q <= l1_q;
            d1_q <= push_data; l1_q <= last_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tvalid = (occ_q != 2'd0);
  assign m_axis_tdata  = d0_q;
  assign m_axis_tlast  = l0_q;
  assign burst_cnt     = bcnt_q;

endmodule

// File: tb/tb_axi_burst_gate.sv
module tb_axi_burst_gate;
  localparam int DW = 32;
  localparam int BL = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          s_tvalid;
  logic [DW-1:0] s_tdata;
  logic          s_tready;
  logic          afull;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tready;
  logic [CW-1:0] burst_cnt;
  logic          pad_active;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  axi_burst_gate #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW), .PAD_TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tready(s_tready),
    .fifo_almost_full(afull),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .burst_cnt(burst_cnt), .pad_active(pad_active)
  );

  // Stimulus only: reset pulse, returns on the negedge where reset_n is released.
  task automatic do_reset(input logic af);
    @(negedge clk);
    reset_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0; afull = af;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_n = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1; afull = 1'b0;
    #1;
    tot_cnt++;
    if ({m_tvalid, m_tlast, s_tready, pad_active} !== 4'b0 || m_tdata !== '0 || burst_cnt !== '0)
      $display("FAIL reset_outputs: got v=%b l=%b r=%b p=%b d=%0h bc=%0d want all 0",
               m_tvalid, m_tlast, s_tready, pad_active, m_tdata, burst_cnt);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    tot_cnt++;
    if (s_tready !== 1'b0) $display("FAIL reset_release_idle: s_tready=%b want 0", s_tready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int in_cnt = 0, out_cnt = 0, k = 0, first_k = -1;
    do_reset(1'b0);
    m_tready = 1'b1; s_tvalid = 1'b1;
    while (out_cnt < 48 && k < 200) begin
      @(negedge clk); k++;
      if (m_tvalid && first_k < 0) first_k = k;
      if (first_k >= 0) begin
        tot_cnt++;
        if (m_tvalid !== 1'b1) $display("FAIL b2b_gap: m_tvalid=%b at cycle %0d want 1", m_tvalid, k);
        else pass_cnt++;
      end
      if (m_tvalid && m_tready) begin
        tot_cnt++;
        if (m_tdata !== DW'(out_cnt) || m_tlast !== (out_cnt % BL == BL - 1))
          $display("FAIL b2b_beat: d=%0d l=%b want d=%0d l=%b", m_tdata, m_tlast,
                   out_cnt, (out_cnt % BL == BL - 1));
        else pass_cnt++;
        out_cnt++;
      end
      s_tdata = DW'(in_cnt);
      if (s_tvalid && s_tready) in_cnt++;
    end
    tot_cnt++;
    if (first_k !== 2) $display("FAIL b2b_latency: first valid at %0d want 2", first_k);
    else pass_cnt++;
    tot_cnt++;
    if (out_cnt !== 48) $display("FAIL b2b_count: beats=%0d want 48", out_cnt);
    else pass_cnt++;
    @(negedge clk);
    s_tvalid = 1'b0;
    tot_cnt++;
    if (burst_cnt !== CW'(3)) $display("FAIL b2b_burst_cnt: got %0d want 3", burst_cnt);
    else pass_cnt++;
  endtask

  task automatic test_gated_start;
    do_reset(1'b1);
    s_tvalid = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tot_cnt++;
      if (s_tready !== 1'b0) $display("FAIL gated_hold: s_tready=%b at cycle %0d want 0", s_tready, i);
      else pass_cnt++;
    end
    afull = 1'b0;
    @(negedge clk);
    tot_cnt++;
    if (s_tready !== 1'b1) $display("FAIL gated_release: s_tready=%b want 1", s_tready);
    else pass_cnt++;
    s_tvalid = 1'b0;
  endtask

  task automatic test_mid_burst_af;
    int in_cnt = 0, out_cnt = 0, k = 0;
    do_reset(1'b0);
    m_tready = 1'b1; s_tvalid = 1'b1;
    while (out_cnt < 16 && k < 100) begin
      @(negedge clk); k++;
      if (m_tvalid && m_tready) begin
        tot_cnt++;
        if (m_tdata !== DW'(out_cnt) || m_tlast !== (out_cnt == 15))
          $display("FAIL midaf_beat: d=%0d l=%b want d=%0d l=%b", m_tdata, m_tlast,
                   out_cnt, (out_cnt == 15));
        else pass_cnt++;
        out_cnt++;
      end
      s_tdata = DW'(in_cnt);
      afull = (in_cnt >= 6);
      if (s_tvalid && s_tready) in_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tot_cnt++;
      if (s_tready !== 1'b0 || m_tvalid !== 1'b0)
        $display("FAIL midaf_idle: s_tready=%b m_tvalid=%b want 0 0", s_tready, m_tvalid);
      else pass_cnt++;
    end
    tot_cnt++;
    if (in_cnt !== 16 || burst_cnt !== CW'(1))
      $display("FAIL midaf_totals: accepted=%0d bursts=%0d want 16 1", in_cnt, burst_cnt);
    else pass_cnt++;
    s_tvalid = 1'b0;
  endtask

  task automatic test_random_bp;
    int in_cnt = 0, out_cnt = 0, k = 0;
    logic prev_stall = 1'b0, prev_l = 1'b0;
    logic [DW-1:0] prev_d = '0;
    do_reset(1'b0);
    while (out_cnt < 1000 && k < 6000) begin
      @(negedge clk); k++;
      if (prev_stall) begin
        tot_cnt++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev_d || m_tlast !== prev_l)
          $display("FAIL rbp_stable: v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                   m_tvalid, m_tdata, m_tlast, prev_d, prev_l);
        else pass_cnt++;
      end
      m_tready = 1'($urandom_range(0, 1));
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = DW'(in_cnt);
      if (m_tvalid && m_tready) begin
        tot_cnt++;
        if (m_tdata !== DW'(out_cnt) || m_tlast !== (out_cnt % BL == BL - 1))
          $display("FAIL rbp_beat: d=%0d l=%b want d=%0d l=%b", m_tdata, m_tlast,
                   out_cnt, (out_cnt % BL == BL - 1));
        else pass_cnt++;
        out_cnt++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata; prev_l = m_tlast;
      if (s_tvalid && s_tready) in_cnt++;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    tot_cnt++;
    if (out_cnt !== 1000 || burst_cnt !== CW'(62))
      $display("FAIL rbp_totals: beats=%0d bursts=%0d want 1000 62", out_cnt, burst_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst;
    int in_cnt = 0, out_cnt = 0, k = 0;
    do_reset(1'b0);
    s_tvalid = 1'b1;
    // drain freely for 6 beats, then stall so beats 5 and 6 fill the buffer
    while (!(in_cnt == 7 && !s_tready) && k < 100) begin
      @(negedge clk); k++;
      if (in_cnt == 7 && !s_tready) break;
      m_tready = (in_cnt < 6);
      s_tdata  = DW'(in_cnt);
      if (s_tvalid && s_tready) in_cnt++;
    end
    tot_cnt++;
    if (in_cnt !== 7 || m_tvalid !== 1'b1 || m_tdata !== DW'(5))
      $display("FAIL rmb_full: accepted=%0d v=%b head=%0d want 7 1 5", in_cnt, m_tvalid, m_tdata);
    else pass_cnt++;
    reset_n = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tot_cnt++;
      if ({m_tvalid, m_tlast, s_tready, pad_active} !== 4'b0 || m_tdata !== '0 || burst_cnt !== '0)
        $display("FAIL rmb_reset_outputs: v=%b l=%b r=%b p=%b d=%0h bc=%0d want all 0",
                 m_tvalid, m_tlast, s_tready, pad_active, m_tdata, burst_cnt);
      else pass_cnt++;
      @(negedge clk);
    end
    reset_n = 1'b1;
    in_cnt = 0; k = 0;
    while (out_cnt < 16 && k < 100) begin
      @(negedge clk); k++;
      if (m_tvalid && m_tready) begin
        tot_cnt++;
        if (m_tdata !== DW'(100 + out_cnt) || m_tlast !== (out_cnt == 15))
          $display("FAIL rmb_beat: d=%0d l=%b want d=%0d l=%b", m_tdata, m_tlast,
                   100 + out_cnt, (out_cnt == 15));
        else pass_cnt++;
        out_cnt++;
      end
      s_tdata = DW'(100 + in_cnt);
      if (s_tvalid && s_tready) in_cnt++;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    tot_cnt++;
    if (out_cnt !== 16 || burst_cnt !== CW'(1))
      $display("FAIL rmb_totals: beats=%0d bursts=%0d want 16 1", out_cnt, burst_cnt);
    else pass_cnt++;
  endtask

`ifdef AXI_BURST_GATE_PAD_EN
  task automatic test_pad;
    int in_cnt = 0, out_cnt = 0, k = 0, k_last = -1, k_pad = -1;
    do_reset(1'b0);
    m_tready = 1'b1;
    while (out_cnt < 16 && k < 200) begin
      @(negedge clk); k++;
      if (pad_active && k_pad < 0) k_pad = k;
      if (pad_active) begin
        tot_cnt++;
        if (s_tready !== 1'b0) $display("FAIL pad_tready: s_tready=%b want 0", s_tready);
        else pass_cnt++;
      end
      if (m_tvalid && m_tready) begin
        tot_cnt++;
        if (m_tdata !== ((out_cnt < 5) ? DW'(out_cnt) : '0) || m_tlast !== (out_cnt == 15))
          $display("FAIL pad_beat: idx=%0d d=%0d l=%b want d=%0d l=%b", out_cnt, m_tdata,
                   m_tlast, (out_cnt < 5) ? out_cnt : 0, (out_cnt == 15));
        else pass_cnt++;
        out_cnt++;
      end
      s_tvalid = (in_cnt < 5);
      s_tdata  = DW'(in_cnt);
      if (s_tvalid && s_tready) begin in_cnt++; k_last = k; end
    end
    tot_cnt++;
    if (k_pad - k_last !== 9) $display("FAIL pad_timing: pad after %0d cycles want 9", k_pad - k_last);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if (out_cnt !== 16 || burst_cnt !== CW'(1) || pad_active !== 1'b0)
      $display("FAIL pad_totals: beats=%0d bursts=%0d pad=%b want 16 1 0", out_cnt, burst_cnt, pad_active);
    else pass_cnt++;
  endtask
`endif

  initial begin
    reset_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; afull = 1'b1; m_tready = 1'b0;
    test_reset;
    test_back_to_back;
    test_gated_start;
    test_mid_burst_af;
    test_random_bp;
    test_reset_mid_burst;
`ifdef AXI_BURST_GATE_PAD_EN
    test_pad;
`endif
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
